// File: rtl/alu_pkg.sv
// Shared definitions for the nibble-serial ALU: op-field encodings, the
// binvert bit position and the sequencing state type.
package alu_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SLT = 2'b11;

  // op[BINV] inverts B and doubles as the initial carry-in (subtract)
  localparam int BINV = 2;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/nibble_alu_slice.sv
// Combinational 4-bit ALU slice: AND/OR/ADD/SLT on one nibble with carry
// in/out, plus the signed-overflow and sum-MSB signals needed at the top slice.
module nibble_alu_slice
  import alu_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       binv,
  input  logic       cin,
  input  logic [1:0] op,
  output logic [3:0] result,
  output logic       cout,
  output logic       overflow,
  output logic       sum_msb
);

  logic [3:0] b_eff;
  logic [4:0] sum;
  logic       carry_into_msb;

  always_comb begin
    b_eff          = binv ? ~b : b;
    sum            = {1'b0, a} + {1'b0, b_eff} + {4'b0000, cin};
    carry_into_msb = a[3] ^ b_eff[3] ^ sum[3];
    cout           = sum[4];
    overflow       = carry_into_msb ^ sum[4];
    sum_msb        = sum[3];
    result         = sum[3:0];
    case (op)
      OP_AND:  result = a & b_eff;
      OP_OR:   result = a | b_eff;
      default: result = sum[3:0];
    endcase
  end

endmodule

// File: rtl/nibble_serial_alu.sv
// Sequences WIDTH-bit ALU commands through one 4-bit slice, LSB nibble first,
// with valid/ready handshakes on the command and result sides.
module nibble_serial_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_cout,
  output logic             out_overflow,
  output logic             out_zero
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] LAST_NIB = CW'(NIB - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-5:0] sh_q, sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [2:0]       op_q, op_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic [3:0]       s_result;
  logic             s_cout, s_ovf, s_msb;
  logic [WIDTH-1:0] full_res, final_res;

  nibble_alu_slice u_slice (
    .a        (a_q[3:0]),
    .b        (b_q[3:0]),
    .binv     (op_q[BINV]),
    .cin      (carry_q),
    .op       (op_q[1:0]),
    .result   (s_result),
    .cout     (s_cout),
    .overflow (s_ovf),
    .sum_msb  (s_msb)
  );

  // On the last nibble the shift register plus the slice output is the full
  // word; SLT replaces it with the overflow-corrected sign of the sum.
  always_comb begin
    full_res  = {s_result, sh_q};
    final_res = full_res;
    if (op_q[1:0] == OP_SLT) begin
      final_res = {{(WIDTH-1){1'b0}}, s_msb ^ s_ovf};
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sh_d    = sh_q;
    res_d   = res_q;
    op_d    = op_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          op_d    = in_op;
          carry_d = in_op[BINV];
          cnt_d   = '0;
          sh_d    = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> 4;
        b_d     = b_q >> 4;
        sh_d    = full_res[WIDTH-1:4];
        carry_d = s_cout;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_NIB) begin
          res_d   = final_res;
          zero_d  = (final_res == '0);
          cout_d  = op_q[1] & s_cout;
          ovf_d   = op_q[1] & s_ovf;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sh_q    <= '0;
      res_q   <= '0;
      op_q    <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sh_q    <= sh_d;
      res_q   <= res_d;
      op_q    <= op_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign in_ready     = (state_q == IDLE);
  assign out_valid    = (state_q == DONE);
  assign out_result   = res_q;
  assign out_cout     = cout_q;
  assign out_overflow = ovf_q;
  assign out_zero     = zero_q;

endmodule
